md_unit: RTL

Multiply/divide unit with its HI/LO register file and busy sequencer for the pipelined MIPS core.
- Accepts mult/multu/div/divu from the E stage and holds the unit busy for a fixed latency.
- Commits the result to HI/LO at the end of the latency and drives the decode-stage stall for dependent HI/LO instructions.
- Also services mthi/mtlo writes and supplies HI/LO to mfhi/mflo.

---
 rtl/md_unit.sv | 138 +++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit: HI/LO register file, fixed-latency busy sequencer and D-stage stall.
// Optional feature: define MD_MADD_EN to enable madd/maddu/msub/msubu (md_op 4-7).
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    typedef enum logic {IDLE, RUNNING} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;

    logic          op_signed, is_div, op_valid;
    logic [63:0]   ext_a, ext_b, prod, res;
    logic          neg_a, neg_b;
    logic [31:0]   abs_a, abs_b, divisor, quo_u, rem_u;

    // One shared multiplier: sign- or zero-extend to 64 bits and keep the low 64 bits.
    always_comb begin
        op_signed = ~md_op[0];
        is_div    = (md_op[2:1] == 2'b01);
`ifdef MD_MADD_EN
        op_valid  = 1'b1;
`else
        op_valid  = ~md_op[2];
`endif
        ext_a = op_signed ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
        ext_b = op_signed ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
        prod  = ext_a * ext_b;

        // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
        neg_a   = op_signed & rs_val[31];
        neg_b   = op_signed & rt_val[31];
        abs_a   = neg_a ? -rs_val : rs_val;
        abs_b   = neg_b ? -rt_val : rt_val;
        divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
        quo_u   = abs_a / divisor;
        rem_u   = abs_a % divisor;

        if (is_div) begin
            res = {neg_a ? -rem_u : rem_u, (neg_a ^ neg_b) ? -quo_u : quo_u};
        end else begin
`ifdef MD_MADD_EN
            if (md_op[2]) begin
                res = md_op[1] ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
            end else begin
                res = prod;
            end
`else
            res = prod;
`endif
        end
    end

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start && op_valid) begin
                    state_d   = RUNNING;
                    cnt_d     = is_div ? DIV_N : MULT_N;
                    pend_hi_d = res[63:32];
                    pend_lo_d = res[31:0];
                    pend_wr_d = ~(is_div && (rt_val == 32'd0));
                end else begin
                    if (hi_we) hi_d = rs_val;
                    if (lo_we) lo_d = rs_val;
                end
            end
            RUNNING: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the pending result is cleared too
    // so a reset mid-operation can never leak a stale commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy  = (state_q == RUNNING);
    assign stall = d_is_md & (busy | start);
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule
